ifm_chunk_bank_ring: RTL and testbench

//  N-bank successor of the two-chunk IFM store: holds BANK_NUM sparse IFM chunks (sparsemap + packed nonzero bytes).
//  The IFM loader fills banks round-robin while the compute units read the oldest full bank, with per-bank full/empty state.
//  A valid/ready write handshake and an explicit read-release replace the external wr_sel/rd_sel muxing.

---
 rtl/ifm_chunk_bank_ring_if.sv | 36 +++
 rtl/ifm_chunk_bank_ring.sv | 133 +++++++++++++
 tb/tb_ifm_chunk_bank_ring.sv | 287 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ifm_chunk_bank_ring_if.sv
// Write-beat and read-port bundle between the IFM loader/compute side and the chunk bank ring.
// master = loader + compute units, slave = bank ring.
interface ifm_chunk_bank_ring_if #(
    parameter int BUS_SIZE         = 32,
    parameter int MEM_SIZE         = 128,
    parameter int COMPUTE_UNIT_NUM = 4,
    parameter int PREFIX_SUM_SIZE  = 16
);
    localparam int AW     = $clog2(MEM_SIZE) + 1;
    localparam int SM_NUM = MEM_SIZE / PREFIX_SUM_SIZE;
    localparam int SMW    = (SM_NUM > 1) ? $clog2(SM_NUM) : 1;

    logic                                              wr_valid_i;
    logic                                              wr_ready_o;
    logic [BUS_SIZE-1:0]                               wr_sparsemap_i;
    logic [BUS_SIZE-1:0][7:0]                          wr_nonzero_data_i;
    logic                                              rd_valid_o;
    logic                                              rd_release_i;
    logic [AW-1:0]                                     rd_nz_cnt_o;
    logic [COMPUTE_UNIT_NUM-1:0][AW-1:0]               rd_addr_i;
    logic [COMPUTE_UNIT_NUM-1:0][7:0]                  rd_data_o;
    logic [COMPUTE_UNIT_NUM-1:0][SMW-1:0]              rd_sparsemap_addr_i;
    logic [COMPUTE_UNIT_NUM-1:0][PREFIX_SUM_SIZE-1:0]  rd_sparsemap_o;

    modport master (
        output wr_valid_i, wr_sparsemap_i, wr_nonzero_data_i,
        output rd_release_i, rd_addr_i, rd_sparsemap_addr_i,
        input  wr_ready_o, rd_valid_o, rd_nz_cnt_o, rd_data_o, rd_sparsemap_o
    );

    modport slave (
        input  wr_valid_i, wr_sparsemap_i, wr_nonzero_data_i,
        input  rd_release_i, rd_addr_i, rd_sparsemap_addr_i,
        output wr_ready_o, rd_valid_o, rd_nz_cnt_o, rd_data_o, rd_sparsemap_o
    );
endinterface

// File: rtl/ifm_chunk_bank_ring.sv
// Purpose: ring of BANK_NUM sparse IFM chunk banks, filled round-robin, read oldest-full-first by CU ports.
// Latency: read data/sparsemap registered, 1 cycle after address; rd_nz_cnt_o combinational.
// Backpressure: wr_ready_o low while the write bank is FULL; IFM_RD_ZERO_PAD_EN masks reads past nz count.
module ifm_chunk_bank_ring #(
    parameter int BANK_NUM         = 2,
    parameter int BUS_SIZE         = 32,
    parameter int MEM_SIZE         = 128,
    parameter int COMPUTE_UNIT_NUM = 4,
    parameter int PREFIX_SUM_SIZE  = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    ifm_chunk_bank_ring_if.slave  bus
);
    localparam int WR_BEATS = MEM_SIZE / BUS_SIZE;
    localparam int AW       = $clog2(MEM_SIZE) + 1;
    localparam int IW       = $clog2(MEM_SIZE);
    localparam int SM_NUM   = MEM_SIZE / PREFIX_SUM_SIZE;
    localparam int SMW      = (SM_NUM > 1) ? $clog2(SM_NUM) : 1;
    localparam int BW       = (BANK_NUM > 1) ? $clog2(BANK_NUM) : 1;
    localparam int CW       = $clog2(WR_BEATS);

    typedef enum logic [1:0] {BANK_EMPTY, BANK_FILLING, BANK_FULL} bank_state_t;

    bank_state_t       state [BANK_NUM];
    logic [AW-1:0]     nz_cnt [BANK_NUM];
    logic [BW-1:0]     wr_bank;
    logic [BW-1:0]     rd_bank;
    logic [CW-1:0]     beat_cnt;
    logic [AW-1:0]     nz_ptr;

    logic [MEM_SIZE-1:0] sm_mem [BANK_NUM];
    logic [7:0]          nz_mem [BANK_NUM][MEM_SIZE];

    logic [AW-1:0] beat_pop;
    logic          wr_fire;
    logic          rd_fire;
    logic          last_beat;
    logic [COMPUTE_UNIT_NUM-1:0][7:0]                 data_nxt;
    logic [COMPUTE_UNIT_NUM-1:0][PREFIX_SUM_SIZE-1:0] sm_nxt;

    always_comb begin
        beat_pop = '0;
        for (int j = 0; j < BUS_SIZE; j++) begin
            beat_pop = beat_pop + AW'(bus.wr_sparsemap_i[j]);
        end
    end

    assign bus.wr_ready_o  = (state[wr_bank] != BANK_FULL);
    assign bus.rd_valid_o  = (state[rd_bank] == BANK_FULL);
    assign bus.rd_nz_cnt_o = nz_cnt[rd_bank];
    assign wr_fire         = bus.wr_valid_i && bus.wr_ready_o;
    assign rd_fire         = bus.rd_release_i && bus.rd_valid_o;
    assign last_beat       = (beat_cnt == CW'(WR_BEATS - 1));

    // A write can only target a non-FULL bank and a release only a FULL one, so the two never collide.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int b = 0; b < BANK_NUM; b++) begin
                state[b]  <= BANK_EMPTY;
                nz_cnt[b] <= '0;
            end
            wr_bank  <= '0;
            rd_bank  <= '0;
            beat_cnt <= '0;
            nz_ptr   <= '0;
        end else begin
            for (int b = 0; b < BANK_NUM; b++) begin
                if (wr_fire && (BW'(b) == wr_bank)) begin
                    state[b] <= last_beat ? BANK_FULL : BANK_FILLING;
                end else if (rd_fire && (BW'(b) == rd_bank)) begin
                    state[b] <= BANK_EMPTY;
                end
            end
            if (wr_fire) begin
                if (last_beat) begin
                    nz_cnt[wr_bank] <= nz_ptr + beat_pop;
                    nz_ptr          <= '0;
                    beat_cnt        <= '0;
                    wr_bank         <= (wr_bank == BW'(BANK_NUM - 1)) ? '0 : wr_bank + 1'b1;
                end else begin
                    nz_ptr   <= nz_ptr + beat_pop;
                    beat_cnt <= beat_cnt + 1'b1;
                end
            end
            if (rd_fire) begin
                rd_bank <= (rd_bank == BW'(BANK_NUM - 1)) ? '0 : rd_bank + 1'b1;
            end
        end
    end

    // Bank contents survive reset and release; only the control state is discarded.
    always_ff @(posedge clk_i) begin
        if (wr_fire && !rst_i) begin
            sm_mem[wr_bank][int'(beat_cnt)*BUS_SIZE +: BUS_SIZE] <= bus.wr_sparsemap_i;
            for (int l = 0; l < BUS_SIZE; l++) begin
                if ((AW'(l) < beat_pop) && (int'(nz_ptr) + l < MEM_SIZE)) begin
                    nz_mem[wr_bank][IW'(nz_ptr + AW'(l))] <= bus.wr_nonzero_data_i[l];
                end
            end
        end
    end

    always_comb begin
        for (int k = 0; k < COMPUTE_UNIT_NUM; k++) begin
            data_nxt[k] = '0;
            sm_nxt[k]   = '0;
            if (bus.rd_valid_o) begin
`ifdef IFM_RD_ZERO_PAD_EN
                if ((bus.rd_addr_i[k] != '0) && (int'(bus.rd_addr_i[k]) <= MEM_SIZE) &&
                    (bus.rd_addr_i[k] <= nz_cnt[rd_bank])) begin
`else
                if ((bus.rd_addr_i[k] != '0) && (int'(bus.rd_addr_i[k]) <= MEM_SIZE)) begin
`endif
                    data_nxt[k] = nz_mem[rd_bank][IW'(bus.rd_addr_i[k] - AW'(1))];
                end
                if (int'(bus.rd_sparsemap_addr_i[k]) < SM_NUM) begin
                    sm_nxt[k] = sm_mem[rd_bank][int'(bus.rd_sparsemap_addr_i[k])*PREFIX_SUM_SIZE +: PREFIX_SUM_SIZE];
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            bus.rd_data_o      <= '0;
            bus.rd_sparsemap_o <= '0;
        end else begin
            bus.rd_data_o      <= data_nxt;
            bus.rd_sparsemap_o <= sm_nxt;
        end
    end
endmodule

// File: tb/tb_ifm_chunk_bank_ring.sv
// Bench for ifm_chunk_bank_ring: directed bank-ring scenarios then random traffic, scoreboarded reads.
module tb_ifm_chunk_bank_ring;
    localparam int NB   = 2;
    localparam int BUS  = 32;
    localparam int MEM  = 128;
    localparam int CU   = 4;
    localparam int PS   = 16;
    localparam int WRB  = MEM / BUS;
    localparam int AW   = $clog2(MEM) + 1;
    localparam int SMN  = MEM / PS;
    localparam int SMW  = (SMN > 1) ? $clog2(SMN) : 1;

    typedef struct packed {
        logic [CU*8-1:0]  d;
        logic [CU*PS-1:0] s;
    } rd_exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ifm_chunk_bank_ring_if #(.BUS_SIZE(BUS), .MEM_SIZE(MEM), .COMPUTE_UNIT_NUM(CU), .PREFIX_SUM_SIZE(PS)) bus();

    ifm_chunk_bank_ring #(.BANK_NUM(NB), .BUS_SIZE(BUS), .MEM_SIZE(MEM),
                          .COMPUTE_UNIT_NUM(CU), .PREFIX_SUM_SIZE(PS)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    // Reference model: which banks hold a complete chunk, plus the raw bytes/sparsemap per bank.
    bit             m_full [NB];
    int             m_cnt  [NB];
    logic [7:0]     m_bytes[NB][MEM];
    logic [MEM-1:0] m_sm   [NB];
    int m_wr_bank = 0, m_rd_bank = 0, m_beat = 0, m_ptr = 0;

    int n_checks = 0;
    int n_fail   = 0;
    rd_exp_t exp_q[$];
    logic rd_req   = 1'b0;
    logic rd_req_q = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_read();
        rd_exp_t e;
        logic [MEM-1:0] tmp;
        int a, sa;
        e = '0;
        for (int k = 0; k < CU; k++) begin
            a  = int'(bus.rd_addr_i[k]);
            sa = int'(bus.rd_sparsemap_addr_i[k]);
            if (m_full[m_rd_bank]) begin
`ifdef IFM_RD_ZERO_PAD_EN
                if (a >= 1 && a <= MEM && a <= m_cnt[m_rd_bank]) e.d[k*8 +: 8] = m_bytes[m_rd_bank][a-1];
`else
                if (a >= 1 && a <= MEM) e.d[k*8 +: 8] = m_bytes[m_rd_bank][a-1];
`endif
                tmp = m_sm[m_rd_bank] >> (sa * PS);
                e.s[k*PS +: PS] = tmp[PS-1:0];
            end
        end
        exp_q.push_back(e);
    endtask

    task automatic model_step();
        bit acc, rel;
        int p;
        if (rst) begin
            for (int b = 0; b < NB; b++) begin
                m_full[b] = 1'b0;
                m_cnt[b]  = 0;
            end
            m_wr_bank = 0; m_rd_bank = 0; m_beat = 0; m_ptr = 0;
            return;
        end
        acc = bus.wr_valid_i && !m_full[m_wr_bank];
        rel = bus.rd_release_i && m_full[m_rd_bank];
        if (acc) begin
            m_sm[m_wr_bank][m_beat*BUS +: BUS] = bus.wr_sparsemap_i;
            p = $countones(bus.wr_sparsemap_i);
            for (int l = 0; l < p; l++) m_bytes[m_wr_bank][m_ptr+l] = bus.wr_nonzero_data_i[l];
            m_ptr += p;
            m_beat++;
            if (m_beat == WRB) begin
                m_full[m_wr_bank] = 1'b1;
                m_cnt[m_wr_bank]  = m_ptr;
                m_ptr = 0;
                m_beat = 0;
                m_wr_bank = (m_wr_bank + 1) % NB;
            end
        end
        if (rel) begin
            m_full[m_rd_bank] = 1'b0;
            m_rd_bank = (m_rd_bank + 1) % NB;
        end
    endtask

    // Inputs are driven at the negedge; tick advances one edge and checks status outputs against the model.
    task automatic tick();
        if (rd_req) model_read();
        model_step();
        @(posedge clk);
        @(negedge clk);
        chk("wr_ready", bus.wr_ready_o, !m_full[m_wr_bank]);
        chk("rd_valid", bus.rd_valid_o, m_full[m_rd_bank]);
        chk("rd_nz_cnt", bus.rd_nz_cnt_o, m_cnt[m_rd_bank]);
    endtask

    task automatic set_wr(input bit v, input logic [BUS-1:0] sm, input logic [BUS-1:0][7:0] d);
        bus.wr_valid_i        = v;
        bus.wr_sparsemap_i    = sm;
        bus.wr_nonzero_data_i = d;
    endtask

    task automatic set_rd(input bit rq, input int a, input int sa);
        rd_req = rq;
        for (int k = 0; k < CU; k++) begin
            bus.rd_addr_i[k]           = AW'(a);
            bus.rd_sparsemap_addr_i[k] = SMW'(sa);
        end
    endtask

    always @(posedge clk) rd_req_q <= rd_req;

    always @(negedge clk) begin
        rd_exp_t e;
        if (rd_req_q) begin
            chk("rd_queue_nonempty", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("rd_data", bus.rd_data_o, e.d);
                chk("rd_sparsemap", bus.rd_sparsemap_o, e.s);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [BUS-1:0][7:0] d;
        logic [BUS-1:0]      sm;
        logic [BUS-1:0]      beat_sm [4];
        bit pend;

        set_wr(1'b0, '0, '0);
        bus.rd_release_i = 1'b0;
        set_rd(1'b0, 0, 0);

        // T1 reset
        rst = 1'b1;
        tick(); tick();
        chk("t1_wr_ready", bus.wr_ready_o, 1);
        chk("t1_rd_valid", bus.rd_valid_o, 0);
        chk("t1_rd_data", bus.rd_data_o, 0);
        chk("t1_rd_sparsemap", bus.rd_sparsemap_o, 0);
        chk("t1_rd_nz_cnt", bus.rd_nz_cnt_o, 0);
        rst = 1'b0;

        // T2 bank0: four beats of 4 nonzeros, bytes 1..16, junk in unused lanes
        for (int b = 0; b < WRB; b++) begin
            for (int l = 0; l < BUS; l++) d[l] = (l < 4) ? 8'(4*b + l + 1) : 8'($urandom);
            set_wr(1'b1, 32'h0000_000F, d);
            tick();
        end
        set_wr(1'b0, '0, '0);
        chk("t2_rd_valid", bus.rd_valid_o, 1);
        chk("t2_nz_cnt", bus.rd_nz_cnt_o, 16);
        set_rd(1'b1, 5, 2);
        tick();
        chk("t2_rd_addr5", bus.rd_data_o[0], 8'h05);
        chk("t3_sm_slice2", bus.rd_sparsemap_o[0], 16'h000F);
        set_rd(1'b0, 0, 0);

        // T3 bank1 with all-zero beats interleaved: 4 nonzeros total
        beat_sm[0] = 32'h0000_0003; beat_sm[1] = 32'h0;
        beat_sm[2] = 32'h0000_0101; beat_sm[3] = 32'h0;
        for (int b = 0; b < WRB; b++) begin
            for (int l = 0; l < BUS; l++) d[l] = 8'(8'h20 + 8*b + l);
            set_wr(1'b1, beat_sm[b], d);
            tick();
        end

        // T4 both banks full: held beat must stall, then release bank0
        chk("t4_wr_ready_full", bus.wr_ready_o, 0);
        for (int l = 0; l < BUS; l++) d[l] = 8'hEE;
        d[0] = 8'hA1; d[1] = 8'hA2;
        set_wr(1'b1, 32'h0000_0003, d);
        for (int i = 0; i < 3; i++) tick();
        chk("t4_stall_rd_nz", bus.rd_nz_cnt_o, 16);
        bus.rd_release_i = 1'b1;
        tick();
        bus.rd_release_i = 1'b0;
        chk("t4_release_rd_valid", bus.rd_valid_o, 1);
        chk("t4_bank1_nz_cnt", bus.rd_nz_cnt_o, 4);
        chk("t4_wr_ready_after_release", bus.wr_ready_o, 1);
        set_rd(1'b1, 3, 0);
        tick();
        chk("t4_bank1_addr3", bus.rd_data_o[0], 8'h30);
        chk("t4_bank1_sm_slice0", bus.rd_sparsemap_o[0], 16'h0003);
        set_rd(1'b0, 0, 0);

        // T5 remaining zero beats into bank0; last one lands with the release of bank1
        for (int l = 0; l < BUS; l++) d[l] = 8'($urandom);
        set_wr(1'b1, '0, d);
        tick(); tick();
        bus.rd_release_i = 1'b1;
        tick();
        bus.rd_release_i = 1'b0;
        set_wr(1'b0, '0, '0);
        chk("t5_rd_valid_stays", bus.rd_valid_o, 1);
        chk("t5_bank0_nz_cnt", bus.rd_nz_cnt_o, 2);
        chk("t5_wr_ready_bank1_empty", bus.wr_ready_o, 1);

        // T6 stale byte beyond the 2 fresh nonzeros
        set_rd(1'b1, 10, 0);
        tick();
`ifdef IFM_RD_ZERO_PAD_EN
        chk("t6_stale_masked", bus.rd_data_o[0], 8'h00);
`else
        chk("t6_stale_raw", bus.rd_data_o[0], 8'h0A);
`endif
        set_rd(1'b1, 1, 0);
        tick();
        chk("t6_fresh_addr1", bus.rd_data_o[0], 8'hA1);
        set_rd(1'b0, 0, 0);
        bus.rd_release_i = 1'b1;
        tick();
        bus.rd_release_i = 1'b0;

        // Dense fill of every bank so no location is left unwritten, then drain
        for (int b = 0; b < NB*WRB; b++) begin
            for (int l = 0; l < BUS; l++) d[l] = 8'($urandom);
            set_wr(1'b1, '1, d);
            tick();
        end
        set_wr(1'b0, '0, '0);
        bus.rd_release_i = 1'b1;
        tick(); tick();
        bus.rd_release_i = 1'b0;

        // Random traffic with stalls, releases, occasional resets and parallel reads
        pend = 1'b0;
        for (int c = 0; c < 1500; c++) begin
            rst = ($urandom_range(0, 199) == 0);
            if (!pend) begin
                for (int l = 0; l < BUS; l++) d[l] = 8'($urandom);
                case ($urandom_range(0, 3))
                    0: sm = '0;
                    1: sm = '1;
                    2: sm = BUS'($urandom);
                    default: sm = BUS'($urandom & $urandom & $urandom);
                endcase
                set_wr($urandom_range(0, 3) != 0, sm, d);
            end
            bus.rd_release_i = ($urandom_range(0, 2) == 0);
            rd_req = !rst && ($urandom_range(0, 1) == 1);
            for (int k = 0; k < CU; k++) begin
                bus.rd_addr_i[k]           = AW'($urandom_range(0, MEM + 4));
                bus.rd_sparsemap_addr_i[k] = SMW'($urandom_range(0, SMN - 1));
            end
            pend = bus.wr_valid_i && (rst || m_full[m_wr_bank]);
            tick();
        end

        rst = 1'b0;
        set_wr(1'b0, '0, '0);
        bus.rd_release_i = 1'b0;
        set_rd(1'b0, 0, 0);
        tick(); tick();
        chk("scoreboard_drained", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
